// File: rtl/wb_master_pkg.sv
// Shared encodings for the Wishbone single-access master and its lane steering helper.
package wb_master_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_BUS_ERR   = 2'd1,
    ST_TIMEOUT   = 2'd2,
    ST_BAD_ALIGN = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Expand a 4-bit byte-enable into a 32-bit lane mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_byte_lane_steer.sv
// Big-endian byte-lane steering for a 32-bit Wishbone port: offset 0 sits on bits [31:24].
module wb_byte_lane_steer
  import wb_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_steered,
  output logic [31:0] rdata_extracted,
  output logic        misaligned
);

  logic [31:0] wdata_rep;
  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;

  // (3 - offset) * 8 and (offset==0 ? 16 : 0) without arithmetic.
  assign byte_shift = {~adr_lo, 3'b000};
  assign half_shift = {~adr_lo[1], 4'b0000};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    sel             = 4'b0000;
    wdata_rep       = '0;
    rdata_extracted = '0;
    misaligned      = 1'b0;
    case (size_e'(size))
      SIZE_BYTE: begin
        sel             = 4'b1000 >> adr_lo;
        wdata_rep       = {4{wdata[7:0]}};
        rdata_extracted = {24'd0, 8'(rdata >> byte_shift)};
      end
      SIZE_HALF: begin
        sel             = adr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep       = {2{wdata[15:0]}};
        rdata_extracted = {16'd0, 16'(rdata >> half_shift)};
        misaligned      = adr_lo[0];
      end
      SIZE_WORD: begin
        sel             = 4'b1111;
        wdata_rep       = wdata;
        rdata_extracted = rdata;
        misaligned      = |adr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign wdata_steered = wdata_rep & sel_to_mask(sel);

endmodule

// File: rtl/wishbone_single_access_master.sv
// Wishbone B3 classic master: one sized read or write per command, one response per command.
module wishbone_single_access_master
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [1:0]  cmd_size_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [1:0]  rsp_status_o,
  output logic [31:0] rsp_dat_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST =
    TMO_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_e                   state;
  logic [1:0]               size_q;
  logic [1:0]               adr_lo_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

  logic [1:0]  steer_size;
  logic [1:0]  steer_adr_lo;
  logic [3:0]  steer_sel;
  logic [31:0] steer_wdata;
  logic [31:0] steer_rdata;
  logic        steer_misaligned;

  logic        bus_done;
  status_e     bus_status;

  // NOTE: cmd_ready is deliberately combinational so a command can be taken on the first idle edge.
  assign cmd_ready_o = (state == ST_IDLE) && !wb_rst_i;

  // The steering block sees the incoming command in IDLE and the latched one during BUS.
  assign steer_size   = (state == ST_IDLE) ? cmd_size_i      : size_q;
  assign steer_adr_lo = (state == ST_IDLE) ? cmd_adr_i[1:0]  : adr_lo_q;

  wb_byte_lane_steer u_steer (
    .size            (steer_size),
    .adr_lo          (steer_adr_lo),
    .wdata           (cmd_dat_i),
    .rdata           (wb_dat_i),
    .sel             (steer_sel),
    .wdata_steered   (steer_wdata),
    .rdata_extracted (steer_rdata),
    .misaligned      (steer_misaligned)
  );

  // Error beats ack when both arrive together.
  always_comb begin
    bus_done   = 1'b1;
    bus_status = ST_OK;
    if (wb_err_i) begin
      bus_status = ST_BUS_ERR;
    end else if (wb_ack_i) begin
      bus_status = ST_OK;
    end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
      bus_status = ST_TIMEOUT;
    end else begin
      bus_done = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; comb logic above uses blocking.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      size_q       <= '0;
      adr_lo_q     <= '0;
      tmo_cnt      <= '0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= ST_OK;
      rsp_dat_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            if (steer_misaligned) begin
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= ST_BAD_ALIGN;
              rsp_dat_o    <= '0;
              state        <= ST_RESP;
            end else begin
              wb_adr_o <= {cmd_adr_i[31:2], 2'b00};
              wb_sel_o <= steer_sel;
              wb_dat_o <= steer_wdata;
              wb_we_o  <= cmd_we_i;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              size_q   <= cmd_size_i;
              adr_lo_q <= cmd_adr_i[1:0];
              tmo_cnt  <= '0;
              state    <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (bus_done) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= bus_status;
            rsp_dat_o    <= (bus_status == ST_OK && !wb_we_o) ? steer_rdata : '0;
            state        <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_single_access_master.sv
// Bench for the single-access master: RAM-like slave, byte-level reference memory, directed and random commands.
module tb_wishbone_single_access_master;
  import wb_master_pkg::*;

  localparam int RAM_BYTES = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready;
  logic [31:0] cmd_adr, cmd_dat, rsp_dat, wb_adr, wb_dat_o, wb_dat_i;
  logic [1:0]  cmd_size, rsp_status;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;

  logic        n_cmd_valid, n_cmd_ready, n_rsp_valid;
  logic [31:0] n_rsp_dat, n_wb_adr, n_wb_dat_o;
  logic [1:0]  n_rsp_status;
  logic [3:0]  n_wb_sel;
  logic        n_wb_we, n_wb_cyc, n_wb_stb;

  wishbone_single_access_master #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_size_i(cmd_size), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_status_o(rsp_status),
    .rsp_dat_o(rsp_dat), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  // Second instance with the timeout disabled, facing a slave that never answers.
  wishbone_single_access_master #(.TIMEOUT_CYCLES(0), .TIMEOUT_WIDTH(8)) dut_nt (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(n_cmd_valid), .cmd_ready_o(n_cmd_ready), .cmd_we_i(1'b0),
    .cmd_adr_i(32'h10), .cmd_size_i(2'd2), .cmd_dat_i(32'h0),
    .rsp_valid_o(n_rsp_valid), .rsp_ready_i(1'b0), .rsp_status_o(n_rsp_status),
    .rsp_dat_o(n_rsp_dat), .wb_adr_o(n_wb_adr), .wb_dat_o(n_wb_dat_o), .wb_dat_i(32'hFFFF_FFFF),
    .wb_sel_o(n_wb_sel), .wb_we_o(n_wb_we), .wb_cyc_o(n_wb_cyc), .wb_stb_o(n_wb_stb),
    .wb_ack_i(1'b0), .wb_err_i(1'b0)
  );

  // ---------------- slave: 2 KiB RAM, one wait state, err beyond the RAM ----------------
  typedef enum {SLV_NORMAL, SLV_SILENT, SLV_BOTH} slave_mode_e;
  slave_mode_e slave_mode;
  logic [31:0] ram [RAM_BYTES/4];
  logic        s_ack, s_err;
  logic [31:0] s_rdata;

  assign wb_ack   = s_ack;
  assign wb_err   = s_err;
  assign wb_dat_i = s_rdata;

  always @(posedge clk) begin
    s_ack   <= 1'b0;
    s_err   <= 1'b0;
    s_rdata <= $urandom;
    if (!rst && wb_cyc && wb_stb && !s_ack && !s_err) begin
      case (slave_mode)
        SLV_NORMAL: begin
          if (wb_adr < RAM_BYTES) begin
            s_ack <= 1'b1;
            if (wb_we) begin
              for (int b = 0; b < 4; b++)
                if (wb_sel[b]) ram[wb_adr[10:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
            end else begin
              s_rdata <= ram[wb_adr[10:2]];
            end
          end else begin
            s_err <= 1'b1;
          end
        end
        SLV_BOTH: begin
          s_ack <= 1'b1;
          s_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] model_mem [RAM_BYTES];

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit exp_misaligned(input logic [1:0] size, input logic [31:0] adr);
    return (size == 2'd3) || ((adr % nbytes(size)) != 0);
  endfunction

  function automatic logic [3:0] exp_sel(input logic [1:0] size, input logic [31:0] adr);
    int n  = nbytes(size);
    int sh = 4 - int'(adr % 4) - n;
    return 4'(((1 << n) - 1) << sh);
  endfunction

  function automatic logic [31:0] exp_wdat(input logic [1:0] size, input logic [31:0] adr,
                                           input logic [31:0] dat);
    int n  = nbytes(size);
    int sh = 4 - int'(adr % 4) - n;
    logic [63:0] masked = {32'd0, dat} & ((64'd1 << (8 * n)) - 64'd1);
    return 32'(masked << (8 * sh));
  endfunction

  // ---------------- checking ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Results of the last run_cmd.
  logic [1:0]  r_status;
  logic [31:0] r_dat, r_wdat;
  logic [3:0]  r_sel;
  int          r_stb_cnt;
  bit          r_cyc_seen, r_bus_stable, r_stable;

  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [1:0] size,
                         input logic [31:0] dat, input int holdoff);
    int budget;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_size = size; cmd_dat = dat;
    budget = 0;
    while (!cmd_ready && budget < 50) begin @(negedge clk); budget++; end
    if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom;
    r_stb_cnt = 0; r_cyc_seen = 0; r_bus_stable = 1; r_sel = '0; r_wdat = '0;
    budget = 0;
    while (!rsp_valid && budget < 200) begin
      if (wb_cyc) r_cyc_seen = 1;
      if (wb_stb) begin
        if (r_stb_cnt == 0) begin r_sel = wb_sel; r_wdat = wb_dat_o; end
        else if (wb_sel !== r_sel || wb_dat_o !== r_wdat) r_bus_stable = 0;
        r_stb_cnt++;
      end
      @(negedge clk);
      budget++;
    end
    if (!rsp_valid) check("rsp_wait", 32'(rsp_valid), 32'd1);
    r_status = rsp_status; r_dat = rsp_dat; r_stable = 1;
    repeat (holdoff) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_status !== r_status || rsp_dat !== r_dat || cmd_ready !== 1'b0)
        r_stable = 0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Run a command against the normal slave and compare with the byte model.
  task automatic do_and_check(input string tag, input logic we, input logic [31:0] adr,
                              input logic [1:0] size, input logic [31:0] dat, input int holdoff);
    logic [31:0] exp_rd;
    run_cmd(we, adr, size, dat, holdoff);
    if (exp_misaligned(size, adr)) begin
      check({tag, "_status"}, 32'(r_status), 32'(ST_BAD_ALIGN));
      check({tag, "_nocyc"}, 32'(r_cyc_seen), 32'd0);
      check({tag, "_dat"}, r_dat, 32'd0);
    end else if (adr >= RAM_BYTES) begin
      check({tag, "_status"}, 32'(r_status), 32'(ST_BUS_ERR));
      check({tag, "_stb"}, 32'(r_stb_cnt), 32'd2);
      check({tag, "_dat"}, r_dat, 32'd0);
    end else begin
      check({tag, "_status"}, 32'(r_status), 32'(ST_OK));
      check({tag, "_stb"}, 32'(r_stb_cnt), 32'd2);
      check({tag, "_sel"}, 32'(r_sel), 32'(exp_sel(size, adr)));
      if (we) begin
        check({tag, "_wdat"}, r_wdat, exp_wdat(size, adr, dat));
        check({tag, "_dat"}, r_dat, 32'd0);
        for (int i = 0; i < nbytes(size); i++)
          model_mem[int'(adr) + i] = 8'(dat >> (8 * (nbytes(size) - 1 - i)));
      end else begin
        exp_rd = '0;
        for (int i = 0; i < nbytes(size); i++)
          exp_rd = (exp_rd << 8) | 32'(model_mem[int'(adr) + i]);
        check({tag, "_rdat"}, r_dat, exp_rd);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cnt;
    bit seen;
    logic        we;
    logic [1:0]  size;
    logic [31:0] adr, dat;

    for (int i = 0; i < RAM_BYTES / 4; i++) ram[i] = '0;
    for (int i = 0; i < RAM_BYTES; i++) model_mem[i] = '0;
    slave_mode = SLV_NORMAL;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_size = '0; cmd_dat = '0;
    rsp_ready = 1'b0; n_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cyc_stb_we", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_status}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Word write then read back
    do_and_check("w_word", 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 0);
    check("w_word_sel_1111", 32'(r_sel), 32'hF);
    check("w_word_wdat", r_wdat, 32'hDEADBEEF);
    do_and_check("r_word", 1'b0, 32'h10, 2'd2, 32'h0, 0);
    check("r_word_value", r_dat, 32'hDEADBEEF);

    // Byte write into a cleared word
    do_and_check("w_clear", 1'b1, 32'h10, 2'd2, 32'h0, 0);
    do_and_check("w_byte", 1'b1, 32'h11, 2'd0, 32'hFFFF_FF5A, 0);
    check("w_byte_sel_0100", 32'(r_sel), 32'h4);
    check("w_byte_wdat", r_wdat, 32'h005A0000);
    do_and_check("r_word2", 1'b0, 32'h10, 2'd2, 32'h0, 0);
    check("r_word2_value", r_dat, 32'h005A0000);
    do_and_check("r_byte", 1'b0, 32'h11, 2'd0, 32'h0, 0);
    check("r_byte_value", r_dat, 32'h0000005A);

    // Alignment errors
    do_and_check("half_0x13", 1'b0, 32'h13, 2'd1, 32'h0, 0);
    do_and_check("size3", 1'b1, 32'h10, 2'd3, 32'h1234, 0);

    // Bus errors
    do_and_check("rd_oob", 1'b0, 32'h0010_0000, 2'd2, 32'h0, 0);
    slave_mode = SLV_BOTH;
    run_cmd(1'b0, 32'h10, 2'd2, 32'h0, 0);
    check("ack_err_status", 32'(r_status), 32'(ST_BUS_ERR));
    check("ack_err_dat", r_dat, 32'd0);
    check("ack_err_stb", 32'(r_stb_cnt), 32'd2);

    // Silent slave, timeout after 4 strobe cycles
    slave_mode = SLV_SILENT;
    run_cmd(1'b0, 32'h10, 2'd2, 32'h0, 0);
    check("tmo_status", 32'(r_status), 32'(ST_TIMEOUT));
    check("tmo_stb", 32'(r_stb_cnt), 32'd4);
    check("tmo_dat", r_dat, 32'd0);
    check("tmo_bus_stable", 32'(r_bus_stable), 32'd1);

    // Timeout disabled: strobe held for 1000 cycles
    @(negedge clk);
    n_cmd_valid = 1'b1;
    @(negedge clk);
    n_cmd_valid = 1'b0;
    cnt = 0;
    repeat (1000) begin
      if (n_wb_cyc && n_wb_stb && !n_rsp_valid) cnt++;
      @(negedge clk);
    end
    check("notmo_stb_1000", 32'(cnt), 32'd1000);

    // Reset during BUS
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h10; cmd_size = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstbus_pre_stb", 32'(wb_stb), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstbus_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("rstbus_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstbus_notmo_cyc", 32'(n_wb_cyc), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc) seen = 1;
    end
    check("rstbus_no_rsp", 32'(seen), 32'd0);
    slave_mode = SLV_NORMAL;
    do_and_check("post_rst_read", 1'b0, 32'h10, 2'd2, 32'h0, 0);

    // Held-off response
    do_and_check("holdoff", 1'b0, 32'h11, 2'd0, 32'h0, 5);
    check("holdoff_stable", 32'(r_stable), 32'd1);
    check("holdoff_released", 32'(rsp_valid), 32'd0);

    // Random commands against the byte model
    for (int k = 0; k < 80; k++) begin
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) adr = 32'h0010_0000 + 32'($urandom_range(0, 255)) * 4;
      else adr = 32'($urandom_range(0, RAM_BYTES - 1));
      if (size != 2'd3 && $urandom_range(0, 3) != 0) adr = adr & ~32'(nbytes(size) - 1);
      dat = $urandom;
      do_and_check($sformatf("rand%0d", k), we, adr, size, dat, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
